// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared pipeline definitions for the ID/EX hazard controller: FSM states,
// the hard-wired zero register, and control-bus bit positions.
package hazard_ctrl_unit_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        BR_WAIT = 1'b1
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // EX memory-control bus {MemRead, MemWrite} and WB bus {RegWrite, MemtoReg}
    localparam int MEM_CTRL_W        = 2;
    localparam int MEM_READ_BIT      = 1;
    localparam int MEM_WRITE_BIT     = 0;
    localparam int WB_CTRL_W         = 2;
    localparam int WB_REG_WRITE_BIT  = 1;
    localparam int WB_MEM_TO_REG_BIT = 0;

    // A source register depends on EX only if it is a real register ($0 never does)
    function automatic logic reg_match(input logic [4:0] r, input logic [4:0] dest);
        return (r != REG_ZERO) && (r == dest);
    endfunction

endpackage

// File: rtl/hazard_ctrl_unit_sat_counter.sv
// Event counter that stops at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Load-use / branch-operand stall and jump flush control for the ID/EX register,
// with saturating stall and flush event counters.
module hazard_ctrl_unit
    import hazard_ctrl_unit_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [4:0]       ID_rs,
    input  logic [4:0]       ID_rt,
    input  logic             ID_UsesRt,
    input  logic             ID_Branch,
    input  logic             EX_MemRead,
    input  logic             EX_RegWrite,
    input  logic [4:0]       EX_DestReg,
    input  logic             EX_jump,
    output logic             PCWrite,
    output logic             IFID_Write,
    output logic             IDEX_Bubble,
    output logic             IFID_Flush,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount,
    output state_t           State
);

    state_t state, state_next;
    logic   src_hit;
    logic   stall_evt;
    logic   flush_evt;

    assign src_hit = reg_match(ID_rs, EX_DestReg) ||
                     (ID_UsesRt && reg_match(ID_rt, EX_DestReg));

    always_comb begin
        PCWrite     = 1'b1;
        IFID_Write  = 1'b1;
        IDEX_Bubble = 1'b0;
        IFID_Flush  = 1'b0;
        stall_evt   = 1'b0;
        flush_evt   = 1'b0;
        state_next  = state;
        if (Reset) begin
            case (state)
                IDLE: begin
                    // A jump squashes the ID instruction, so any stall it needed is moot
                    if (EX_jump) begin
                        IFID_Flush  = 1'b1;
                        IDEX_Bubble = 1'b1;
                        flush_evt   = 1'b1;
                    end else if (EX_MemRead && src_hit) begin
                        PCWrite     = 1'b0;
                        IFID_Write  = 1'b0;
                        IDEX_Bubble = 1'b1;
                        stall_evt   = 1'b1;
                        if (ID_Branch) begin
                            state_next = BR_WAIT;
                        end
                    end else if (ID_Branch && EX_RegWrite && src_hit) begin
                        PCWrite     = 1'b0;
                        IFID_Write  = 1'b0;
                        IDEX_Bubble = 1'b1;
                        stall_evt   = 1'b1;
                    end
                end
                BR_WAIT: begin
                    // Load has moved to MEM; the branch still cannot compare in ID
                    PCWrite     = 1'b0;
                    IFID_Write  = 1'b0;
                    IDEX_Bubble = 1'b1;
                    stall_evt   = 1'b1;
                    state_next  = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    assign State = state;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (Clk),
        .rst_n (Reset),
        .inc   (stall_evt),
        .clear (1'b0),
        .count (StallCount)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (Clk),
        .rst_n (Reset),
        .inc   (flush_evt),
        .clear (1'b0),
        .count (FlushCount)
    );

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Consumer-side controller for the ID/EX pipeline register.
- Watches the EX-stage fields the register produces (MemRead, RegWrite, resolved destination, jump) against the operands of the instruction currently in ID.
- Drives hold, bubble and flush controls back into PC, IF/ID and ID/EX.
- Keeps saturating stall and flush event counters for bring-up debug.

Parameters:
CNT_W, 16, width of the stall and flush event counters

Ports:
Clk  input  1  pipeline clock, rising edge
Reset  input  1  asynchronous reset, active-low (0 = reset asserted)
ID_rs  input  5  rs field of instruction in ID
ID_rt  input  5  rt field of instruction in ID
ID_UsesRt  input  1  ID instruction reads rt as a source
ID_Branch  input  1  ID instruction is a branch compared in ID
EX_MemRead  input  1  EX instruction is a load (taken from EX memory-control bus)
EX_RegWrite  input  1  EX instruction writes a register (taken from EX write-back control bus)
EX_DestReg  input  5  EX destination register after the RegDst mux
EX_jump  input  1  jump resolved in EX
PCWrite  output  1  1 = PC may update
IFID_Write  output  1  1 = IF/ID may load
IDEX_Bubble  output  1  1 = ID/EX loads all-zero control (nop)
IFID_Flush  output  1  1 = IF/ID loads nop instruction
StallCount  output  CNT_W  number of stall cycles
FlushCount  output  CNT_W  number of jump flushes

Behaviour:
- Reset (Reset=0, asynchronous): state=IDLE, StallCount=0, FlushCount=0.
- Outputs while in reset: PCWrite=1, IFID_Write=1, IDEX_Bubble=0, IFID_Flush=0.
- Control outputs are combinational from state and current inputs. Counters are registered.
- Match term: match(r) = (r != 0) && (r == EX_DestReg). $0 never matches.
- src_hit = match(ID_rs) || (ID_UsesRt && match(ID_rt)).
- States: IDLE, BR_WAIT.
- IDLE, priority order (highest first):
  1. EX_jump=1: IFID_Flush=1, IDEX_Bubble=1, PCWrite=1, IFID_Write=1. FlushCount+1. Stay IDLE. The jump wins over any stall condition in the same cycle.
  2. Load-use: EX_MemRead && src_hit. Drive PCWrite=0, IFID_Write=0, IDEX_Bubble=1. StallCount+1.
     - If ID_Branch=1, next state = BR_WAIT.
     - Otherwise, stay IDLE. Total stall is 1 cycle.
  3. Branch-ALU: ID_Branch && EX_RegWrite && !EX_MemRead && src_hit. Stall as in rule 2 for 1 cycle. StallCount+1. Stay IDLE.
  4. Otherwise: PCWrite=1, IFID_Write=1, IDEX_Bubble=0, IFID_Flush=0.
- BR_WAIT: unconditional second stall cycle (the load is now in MEM).
  - PCWrite=0, IFID_Write=0, IDEX_Bubble=1. StallCount+1. Next state = IDLE.
  - EX_jump is ignored here; it cannot occur, because EX holds a bubble.
- Resulting stall lengths: load→branch = 2 cycles; load→ALU-use = 1 cycle; ALU→branch = 1 cycle.
- Counters saturate at all-ones and never wrap. The increment and the saturation check happen in the same edge.
- Reset asserted in BR_WAIT returns to IDLE immediately. Counters clear.
- ID_rs/ID_rt equal to 0 never stall, even when EX_DestReg=0 and EX_MemRead=1.

Decomposition:
- Shared pipeline package holds:
  - state enum (IDLE, BR_WAIT)
  - REG_ZERO = 5'd0
  - bit indices of MemRead within the MEM control bus and RegWrite within the WB control bus
- One sub-module: sat_counter (width parameter; inc, clear, count). Instantiated twice.

Test Plan:
1. Load-use: EX_MemRead=1, EX_DestReg=8, ID_rs=8, ID_Branch=0 → one cycle with PCWrite=0, IFID_Write=0, IDEX_Bubble=1; next cycle (EX_MemRead=0) all normal; StallCount=1.
2. Load→branch: EX_MemRead=1, EX_DestReg=9, ID_rt=9, ID_UsesRt=1, ID_Branch=1 → stall in IDLE cycle, then stall in BR_WAIT, then normal; StallCount=2.
3. Jump vs stall: EX_jump=1 together with a load-use match on reg 5 → IFID_Flush=1, IDEX_Bubble=1, PCWrite=1; FlushCount=1, StallCount=0.
4. Zero register: EX_MemRead=1, EX_DestReg=0, ID_rs=0 → no stall; PCWrite=1.
5. Saturation: CNT_W=4, force 20 load-use events → StallCount holds at 15.
6. Async reset: drop Reset to 0 mid-cycle while in BR_WAIT → state IDLE and counters 0 without waiting for a clock edge; PCWrite=1 while reset is held.
